// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer: op codes, FSM states,
// datapath widths and the latched instruction payload.
package alu_pkg;

   localparam int unsigned DW   = 16;
   localparam int unsigned NREG = 8;
   localparam int unsigned AW   = 3;
   localparam int unsigned OPW  = 4;
   localparam int unsigned CW   = 16;

   localparam logic [OPW-1:0] OP_PASS_S = 4'h0;
   localparam logic [OPW-1:0] OP_PASS_R = 4'h1;
   localparam logic [OPW-1:0] OP_ADD    = 4'h2;
   localparam logic [OPW-1:0] OP_SUB    = 4'h3;
   localparam logic [OPW-1:0] OP_INC_S  = 4'h4;
   localparam logic [OPW-1:0] OP_DEC_S  = 4'h5;
   localparam logic [OPW-1:0] OP_SHL_S  = 4'h6;
   localparam logic [OPW-1:0] OP_SHR_S  = 4'h7;
   localparam logic [OPW-1:0] OP_AND    = 4'h8;
   localparam logic [OPW-1:0] OP_OR     = 4'h9;
   localparam logic [OPW-1:0] OP_XOR    = 4'hA;
   localparam logic [OPW-1:0] OP_NOT_S  = 4'hB;
   localparam logic [OPW-1:0] OP_NEG_S  = 4'hC;
   localparam logic [OPW-1:0] OP_LOADI  = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_e;

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [AW-1:0]  dst;
      logic [AW-1:0]  srcr;
      logic [AW-1:0]  srcs;
      logic [DW-1:0]  imm;
   } ins_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU. C is the bit shifted or carried/borrowed out of
// the top of the result; logical and pass operations clear it.
module alu
   import alu_pkg::*;
(
   input  logic [DW-1:0]  r,
   input  logic [DW-1:0]  s,
   input  logic [OPW-1:0] op,
   output logic [DW-1:0]  y_c,
   output logic           n_c,
   output logic           z_c,
   output logic           c_c
);

   logic [DW:0] wide;

   // One extra bit on top of every result carries C.
   always_comb begin
      wide = {1'b0, s};
      case (op)
         OP_PASS_S: wide = {1'b0, s};
         OP_PASS_R: wide = {1'b0, r};
         OP_ADD:    wide = {1'b0, r} + {1'b0, s};
         OP_SUB:    wide = {1'b0, r} - {1'b0, s};
         OP_INC_S:  wide = {1'b0, s} + {{DW{1'b0}}, 1'b1};
         OP_DEC_S:  wide = {1'b0, s} - {{DW{1'b0}}, 1'b1};
         OP_SHL_S:  wide = {s, 1'b0};
         OP_SHR_S:  wide = {s[0], 1'b0, s[DW-1:1]};
         OP_AND:    wide = {1'b0, r & s};
         OP_OR:     wide = {1'b0, r | s};
         OP_XOR:    wide = {1'b0, r ^ s};
         OP_NOT_S:  wide = {1'b0, ~s};
         OP_NEG_S:  wide = {(DW+1){1'b0}} - {1'b0, s};
         default:   wide = {1'b0, s};
      endcase
      y_c = wide[DW-1:0];
      c_c = wide[DW];
      n_c = wide[DW-1];
      z_c = (wide[DW-1:0] == '0);
   end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state controller that reads two registers, runs the ALU and writes the
// result back, one instruction at a time over a valid/ready handshake.
module alu_sequencer
   import alu_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           ins_valid,
   output logic           ins_ready,
   input  logic [OPW-1:0] ins_op,
   input  logic [AW-1:0]  ins_dst,
   input  logic [AW-1:0]  ins_srcr,
   input  logic [AW-1:0]  ins_srcs,
   input  logic [DW-1:0]  ins_imm,
   output logic           done,
   output logic           flag_n,
   output logic           flag_z,
   output logic           flag_c,
   output logic [CW-1:0]  instr_count,
   input  logic [AW-1:0]  dbg_addr,
   output logic [DW-1:0]  dbg_data
);

   state_e        state;
   state_e        state_nxt;
   logic          accept_c;
   ins_t          ins_q;
   logic [DW-1:0] regs [NREG];
   logic [DW-1:0] op_r;
   logic [DW-1:0] op_s;
   logic [DW-1:0] res;
   logic [DW-1:0] alu_y;
   logic          alu_n;
   logic          alu_z;
   logic          alu_c;
   logic [CW-1:0] count_nxt;

   alu u_alu (
      .r   (op_r),
      .s   (op_s),
      .op  (ins_q.op),
      .y_c (alu_y),
      .n_c (alu_n),
      .z_c (alu_z),
      .c_c (alu_c)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      case (state)
         IDLE: begin
            if (ins_valid && ins_ready) begin
               accept_c  = 1'b1;
               state_nxt = READ;
            end
         end
         READ:    state_nxt = EXEC;
         EXEC:    state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign count_nxt = (state == WB) ? instr_count + CW'(1) : instr_count;

   // done rises on the write-back edge, so it coincides with the new register value.
   always_ff @(posedge clk) begin
      if (reset) begin
         ins_ready   <= 1'b1;
         done        <= 1'b0;
         ins_q       <= '0;
         op_r        <= '0;
         op_s        <= '0;
         res         <= '0;
         flag_n      <= 1'b0;
         flag_z      <= 1'b0;
         flag_c      <= 1'b0;
         instr_count <= '0;
      end else begin
         ins_ready   <= (state_nxt == IDLE);
         done        <= (state == WB);
         instr_count <= count_nxt;
         if (accept_c) begin
            ins_q.op   <= ins_op;
            ins_q.dst  <= ins_dst;
            ins_q.srcr <= ins_srcr;
            ins_q.srcs <= ins_srcs;
            ins_q.imm  <= ins_imm;
         end
         if (state == READ) begin
            op_r <= regs[ins_q.srcr];
            op_s <= regs[ins_q.srcs];
         end
         if (state == EXEC) begin
            if (ins_q.op == OP_LOADI) begin
               res <= ins_q.imm;
            end else begin
               res    <= alu_y;
               flag_n <= alu_n;
               flag_z <= alu_z;
               flag_c <= alu_c;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) regs[AW'(i)] <= '0;
      end else if (state == WB) begin
         regs[ins_q.dst] <= res;
      end
   end

   assign dbg_data = regs[dbg_addr];

endmodule
